// File: rtl/sat_sub_acc.sv
// sat_sub_acc: streaming saturating subtract-accumulator with sticky saturation flag
module sat_sub_acc #(
  parameter int DATAW = 32,
  parameter int LENW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DATAW-1:0] init_i,
  input  logic [LENW-1:0]  len_i,
  output logic             busy_o,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [DATAW-1:0] a_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [DATAW-1:0] res_data_o,
  output logic             res_sat_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [DATAW-1:0] r_acc, w_diff, w_res;
  logic [LENW-1:0] r_cnt;
  logic r_sat, w_ovf_pos, w_ovf_neg, w_hs;
  assign w_hs = a_valid_i && a_ready_o;
  assign w_diff = r_acc - a_data_i;
  assign w_ovf_pos = !r_acc[DATAW-1] && a_data_i[DATAW-1] && w_diff[DATAW-1];
  assign w_ovf_neg = r_acc[DATAW-1] && !a_data_i[DATAW-1] && !w_diff[DATAW-1];
  assign w_res = w_ovf_pos ? {1'b0, {(DATAW-1){1'b1}}} :
                 w_ovf_neg ? {1'b1, {(DATAW-1){1'b0}}} : w_diff;
  assign busy_o = r_state != IDLE;
  assign a_ready_o = r_state == RUN;
  assign res_valid_o = r_state == DONE;
  assign res_data_o = r_acc;
  assign res_sat_o = r_sat;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && start_i) w_next = (len_i == '0) ? DONE : RUN;
    if (r_state == RUN && w_hs && r_cnt == LENW'(1)) w_next = DONE;
    if (r_state == DONE && res_ready_i) w_next = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_i) begin
        r_acc <= init_i;
        r_cnt <= len_i;
        r_sat <= 1'b0;
      end else if (w_hs) begin
        r_acc <= w_res;
        r_cnt <= r_cnt - LENW'(1);
        r_sat <= r_sat | w_ovf_pos | w_ovf_neg;
      end
    end
  end
endmodule

// File: tb/tb_sat_sub_acc.sv
// tb_sat_sub_acc: directed scoreboard bench for sat_sub_acc at DATAW=8, LENW=4
module tb_sat_sub_acc;
  logic clk = 0, rst = 1, start = 0, a_valid = 0, res_ready = 1;
  logic [7:0] init = 0, a_data = 0;
  logic [3:0] len = 0;
  logic busy, a_ready, res_valid, res_sat;
  logic [7:0] res_data;
  logic [8:0] q[$];
  int tests = 0, fails = 0;

  sat_sub_acc #(.DATAW(8), .LENW(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .init_i(init), .len_i(len),
    .busy_o(busy), .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_sat_o(res_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic start_job(input logic [7:0] i, input logic [3:0] l);
    wait_idle();
    start = 1;
    init = i;
    len = l;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    a_valid = 1;
    a_data = d;
    while (!a_ready && n < 20) begin
      tick();
      n++;
    end
    if (!a_ready) begin
      tests++;
      fails++;
      $display("FAIL send timeout: a_ready %0b required 1", a_ready);
    end else tick();
    a_valid = 0;
  endtask

  // Compare every cycle the result is presented, so a stall also checks stability
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected result: got %0h with empty scoreboard", {res_sat, res_data});
      end else begin
        chk("result", {23'd0, res_sat, res_data}, {23'd0, q[0]});
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #2;
    chk("reset outputs", {busy, a_ready, res_valid, res_sat, res_data}, 0);
    tick();
    rst = 0;
    // 1: simple back-to-back
    q.push_back({1'b0, 8'd4});
    start_job(8'd10, 4'd3);
    send(8'd3);
    send(8'd2);
    chk("t1 valid before last", res_valid, 0);
    send(8'd1);
    chk("t1 latency", res_valid, 1);
    // 2: positive saturation then continue
    q.push_back({1'b1, 8'h75});
    start_job(8'd100, 4'd2);
    send(8'h9C);
    send(8'd10);
    // 3: negative saturation and subtracting min negative from zero
    q.push_back({1'b1, 8'h80});
    start_job(8'h9C, 4'd1);
    send(8'd100);
    q.push_back({1'b1, 8'h7F});
    start_job(8'h00, 4'd1);
    send(8'h80);
    // 4: zero-length job
    q.push_back({1'b0, 8'h55});
    start_job(8'h55, 4'd0);
    chk("t4 latency", res_valid, 1);
    chk("t4 a_ready", a_ready, 0);
    tick();
    chk("t4 a_ready after", a_ready, 0);
    chk("t4 idle", busy, 0);
    // 5: gaps, stray start, result stall
    q.push_back({1'b0, 8'h19});
    start_job(8'h32, 4'd4);
    send(8'd5);
    start = 1;
    init = 8'h7F;
    len = 4'd1;
    tick();
    start = 0;
    chk("t5 still running", {busy, a_ready}, 2'b11);
    send(8'd10);
    tick();
    tick();
    send(8'hF6);
    tick();
    res_ready = 0;
    send(8'd20);
    chk("t5 valid", res_valid, 1);
    repeat (5) tick();
    chk("t5 stalled data", {res_valid, res_sat, res_data}, {2'b10, 8'h19});
    res_ready = 1;
    tick();
    chk("t5 idle after accept", {busy, res_valid}, 0);
    // 6: reset mid-run, then new job
    start_job(8'h20, 4'd4);
    send(8'd1);
    send(8'd2);
    rst = 1;
    #1;
    chk("t6 reset outputs", {busy, a_ready, res_valid, res_sat, res_data}, 0);
    tick();
    rst = 0;
    q.push_back({1'b0, 8'hFE});
    start_job(8'd5, 4'd1);
    send(8'd7);
    chk("t6 latency", res_valid, 1);
    wait_idle();
    tick();
    chk("scoreboard empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
